// File: rtl/reorder_queue_pkg.sv
// Shared CPU package for the reorder queue.
// Holds the entry-type encodings carried from dispatch to commit and the
// register-id / data widths used by the commit ports.
package reorder_queue_pkg;

    typedef enum logic [1:0] {
        ENT_REG    = 2'b00,
        ENT_BRANCH = 2'b01,
        ENT_STORE  = 2'b10,
        ENT_RSVD   = 2'b11   // behaves like a register op that writes nothing
    } entryType_t;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

endpackage

// File: rtl/rob_wb_select.sv
// Writeback match for one entry index.
// Ports:
//   queryIndex  entry index being looked up
//   wbValid     per-channel writeback valid
//   wbIndex     packed per-channel target indices, channel 0 in the LSBs
//   wbValue     packed per-channel results, channel 0 in the LSBs
//   hit         some valid channel targets queryIndex this cycle
//   value       result of the highest-numbered matching channel
module rob_wb_select
    import reorder_queue_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int NUM_WB    = 2
) (
    input  logic [ROB_WIDTH-1:0]        queryIndex,
    input  logic [NUM_WB-1:0]           wbValid,
    input  logic [NUM_WB*ROB_WIDTH-1:0] wbIndex,
    input  logic [NUM_WB*DATA_W-1:0]    wbValue,
    output logic                        hit,
    output logic [DATA_W-1:0]           value
);

    // Ascending scan: a later (higher) channel overrides an earlier match.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (wbValid[c] && (wbIndex[c*ROB_WIDTH +: ROB_WIDTH] == queryIndex)) begin
                hit   = 1'b1;
                value = wbValue[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reorder_queue.sv
// Reorder queue: in-order allocation, out-of-order writeback, in-order commit.
// Ports:
//   clockIn, resetIn (async, active-low)
//   disp*        allocation request and entry payload; dispIndex = tail
//   full, empty  occupancy flags (full keeps FULL_MARGIN entries in reserve)
//   wb*          NUM_WB packed writeback channels
//   rs1*/rs2*    operand lookups with same-cycle writeback bypass
//   regCommit*   registered register-commit pulse and payload
//   storeCommit* registered store-retire pulse and index
//   clear, newPc registered flush pulse and redirect PC
module reorder_queue
    import reorder_queue_pkg::*;
#(
    parameter int ROB_WIDTH   = 4,
    parameter int ROB_SIZE    = 2**ROB_WIDTH,
    parameter int NUM_WB      = 2,
    parameter int FULL_MARGIN = 2
) (
    input  logic                        clockIn,
    input  logic                        resetIn,
    input  logic                        dispValid,
    input  logic [1:0]                  dispType,
    input  logic [4:0]                  dispDest,
    input  logic                        dispReady,
    input  logic [31:0]                 dispValue,
    input  logic                        dispPredTaken,
    input  logic [31:0]                 dispAltPc,
    output logic [ROB_WIDTH-1:0]        dispIndex,
    output logic                        full,
    output logic                        empty,
    input  logic [NUM_WB-1:0]           wbValid,
    input  logic [NUM_WB*ROB_WIDTH-1:0] wbIndex,
    input  logic [NUM_WB*32-1:0]        wbValue,
    input  logic [ROB_WIDTH-1:0]        rs1Dep,
    input  logic [ROB_WIDTH-1:0]        rs2Dep,
    output logic                        rs1Ready,
    output logic                        rs2Ready,
    output logic [31:0]                 rs1Value,
    output logic [31:0]                 rs2Value,
    output logic                        regCommitValid,
    output logic [4:0]                  regCommitDest,
    output logic [31:0]                 regCommitValue,
    output logic [ROB_WIDTH-1:0]        regCommitIndex,
    output logic                        storeCommitValid,
    output logic [ROB_WIDTH-1:0]        storeCommitIndex,
    output logic                        clear,
    output logic [31:0]                 newPc
);

    localparam int                   FULL_LVL = ROB_SIZE - FULL_MARGIN;
    localparam int                   LAST_LVL = ROB_SIZE - 1;
    localparam logic [ROB_WIDTH:0]   SIZE_C   = ROB_SIZE[ROB_WIDTH:0];
    localparam logic [ROB_WIDTH:0]   FULL_C   = FULL_LVL[ROB_WIDTH:0];
    localparam logic [ROB_WIDTH-1:0] LAST_C   = LAST_LVL[ROB_WIDTH-1:0];

    logic [ROB_WIDTH-1:0] head, tail;
    logic [ROB_WIDTH:0]   count;
    logic [ROB_SIZE-1:0]  entValid, entReady, entPredTaken;
    entryType_t           entType  [ROB_SIZE];
    logic [REG_W-1:0]     entDest  [ROB_SIZE];
    logic [DATA_W-1:0]    entValue [ROB_SIZE];
    logic [DATA_W-1:0]    entAltPc [ROB_SIZE];

    logic [ROB_SIZE-1:0]  entHit;
    logic [DATA_W-1:0]    entWbValue [ROB_SIZE];
    logic                 rs1Hit, rs2Hit;
    logic [DATA_W-1:0]    rs1Byp, rs2Byp;

    for (genvar i = 0; i < ROB_SIZE; i++) begin : gEntWb
        rob_wb_select #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) uSel (
            .queryIndex(ROB_WIDTH'(i)), .wbValid(wbValid), .wbIndex(wbIndex),
            .wbValue(wbValue), .hit(entHit[i]), .value(entWbValue[i])
        );
    end

    rob_wb_select #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) uRs1Sel (
        .queryIndex(rs1Dep), .wbValid(wbValid), .wbIndex(wbIndex),
        .wbValue(wbValue), .hit(rs1Hit), .value(rs1Byp)
    );
    rob_wb_select #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) uRs2Sel (
        .queryIndex(rs2Dep), .wbValid(wbValid), .wbIndex(wbIndex),
        .wbValue(wbValue), .hit(rs2Hit), .value(rs2Byp)
    );

    assign rs1Ready  = (entValid[rs1Dep] && entReady[rs1Dep]) || rs1Hit;
    assign rs2Ready  = (entValid[rs2Dep] && entReady[rs2Dep]) || rs2Hit;
    assign rs1Value  = rs1Hit ? rs1Byp : entValue[rs1Dep];
    assign rs2Value  = rs2Hit ? rs2Byp : entValue[rs2Dep];

    assign dispIndex = tail;
    assign full      = (count >= FULL_C);
    assign empty     = (count == '0);

    // Commit decision: the head retires only once its result is stored.
    logic       headFire, branchMiss, flushNow, popNow, allocNow;
    entryType_t headType;

    assign headType   = entType[head];
    assign headFire   = !clear && entValid[head] && entReady[head];
    assign branchMiss = (headType == ENT_BRANCH) && (entValue[head][0] != entPredTaken[head]);
    assign flushNow   = headFire && branchMiss;
    assign popNow     = headFire && !branchMiss;
    assign allocNow   = dispValid && (count < SIZE_C) && !clear && !flushNow;

    // Control state and registered commit/flush outputs.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            entValid         <= '0;
            regCommitValid   <= 1'b0;
            regCommitDest    <= '0;
            regCommitValue   <= '0;
            regCommitIndex   <= '0;
            storeCommitValid <= 1'b0;
            storeCommitIndex <= '0;
            clear            <= 1'b0;
            newPc            <= '0;
        end else begin
            regCommitValid   <= 1'b0;
            storeCommitValid <= 1'b0;
            clear            <= 1'b0;
            if (flushNow) begin
                entValid <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                clear    <= 1'b1;
                newPc    <= entAltPc[head];
            end else begin
                if (popNow) begin
                    entValid[head] <= 1'b0;
                    head           <= (head == LAST_C) ? '0 : head + 1'b1;
                    if (headType == ENT_REG) begin
                        regCommitValid <= 1'b1;
                        regCommitDest  <= entDest[head];
                        regCommitValue <= entValue[head];
                        regCommitIndex <= head;
                    end
                    if (headType == ENT_STORE) begin
                        storeCommitValid <= 1'b1;
                        storeCommitIndex <= head;
                    end
                end
                if (allocNow) begin
                    entValid[tail] <= 1'b1;
                    tail           <= (tail == LAST_C) ? '0 : tail + 1'b1;
                end
                case ({allocNow, popNow})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry payload; meaningful only while the matching valid bit is set.
    always_ff @(posedge clockIn) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (!clear && entHit[i] && entValid[i]) begin
                entReady[i] <= 1'b1;
                entValue[i] <= entWbValue[i];
            end
        end
        if (allocNow) begin
            entType[tail]      <= entryType_t'(dispType);
            entDest[tail]      <= dispDest;
            entReady[tail]     <= dispReady;
            entValue[tail]     <= dispValue;
            entPredTaken[tail] <= dispPredTaken;
            entAltPc[tail]     <= dispAltPc;
        end
    end

endmodule

// File: tb/tb_reorder_queue.sv
module tb_reorder_queue;
    import reorder_queue_pkg::*;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        dispValid, dispReady, dispPredTaken;
    logic [1:0]  dispType;
    logic [4:0]  dispDest;
    logic [31:0] dispValue, dispAltPc;
    logic [3:0]  dispIndex;
    logic        full, empty;
    logic [1:0]  wbValid;
    logic [7:0]  wbIndex;
    logic [63:0] wbValue;
    logic [3:0]  rs1Dep, rs2Dep;
    logic        rs1Ready, rs2Ready;
    logic [31:0] rs1Value, rs2Value;
    logic        regCommitValid, storeCommitValid, clear;
    logic [4:0]  regCommitDest;
    logic [31:0] regCommitValue, newPc;
    logic [3:0]  regCommitIndex, storeCommitIndex;

    typedef struct packed {
        logic        isStore;
        logic [4:0]  dest;
        logic [31:0] value;
        logic [3:0]  index;
    } exp_t;

    exp_t       sbQ[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] modelTail;

    reorder_queue dut (
        .clockIn(clockIn), .resetIn(resetIn),
        .dispValid(dispValid), .dispType(dispType), .dispDest(dispDest),
        .dispReady(dispReady), .dispValue(dispValue), .dispPredTaken(dispPredTaken),
        .dispAltPc(dispAltPc), .dispIndex(dispIndex), .full(full), .empty(empty),
        .wbValid(wbValid), .wbIndex(wbIndex), .wbValue(wbValue),
        .rs1Dep(rs1Dep), .rs2Dep(rs2Dep), .rs1Ready(rs1Ready), .rs2Ready(rs2Ready),
        .rs1Value(rs1Value), .rs2Value(rs2Value),
        .regCommitValid(regCommitValid), .regCommitDest(regCommitDest),
        .regCommitValue(regCommitValue), .regCommitIndex(regCommitIndex),
        .storeCommitValid(storeCommitValid), .storeCommitIndex(storeCommitIndex),
        .clear(clear), .newPc(newPc)
    );

    always #5 clockIn = ~clockIn;

    // Scoreboard: every commit pulse must match the oldest expected retirement.
    always @(negedge clockIn) begin : monitor
        exp_t e;
        if (resetIn && (regCommitValid || storeCommitValid)) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected reg=%0b store=%0b regIdx=%0d storeIdx=%0d",
                         regCommitValid, storeCommitValid, regCommitIndex, storeCommitIndex);
            end else begin
                e = sbQ.pop_front();
                if (e.isStore) begin
                    if (storeCommitValid !== 1'b1 || regCommitValid !== 1'b0 ||
                        storeCommitIndex !== e.index) begin
                        errors++;
                        $display("FAIL store_commit got st=%0b rg=%0b idx=%0d want idx=%0d",
                                 storeCommitValid, regCommitValid, storeCommitIndex, e.index);
                    end
                end else begin
                    if (regCommitValid !== 1'b1 || storeCommitValid !== 1'b0 ||
                        regCommitDest !== e.dest || regCommitValue !== e.value ||
                        regCommitIndex !== e.index) begin
                        errors++;
                        $display("FAIL reg_commit got v=%0b dest=%0d val=%h idx=%0d want dest=%0d val=%h idx=%0d",
                                 regCommitValid, regCommitDest, regCommitValue, regCommitIndex,
                                 e.dest, e.value, e.index);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clockIn);
        #1;
    endtask

    task automatic idleInputs;
        dispValid = 0; dispType = 0; dispDest = 0; dispReady = 0; dispValue = 0;
        dispPredTaken = 0; dispAltPc = 0; wbValid = 0; wbIndex = 0; wbValue = 0;
        rs1Dep = 0; rs2Dep = 0;
    endtask

    task automatic applyReset;
        resetIn = 1'b0;
        idleInputs();
        sbQ.delete();
        modelTail = 0;
        repeat (2) @(posedge clockIn);
        #2 resetIn = 1'b1;
        tick();
    endtask

    task automatic dispatch(input logic [1:0] t, input logic [4:0] d, input logic rdy,
                            input logic [31:0] v, input logic pred, input logic [31:0] alt,
                            input logic expCommit, input logic isSt, input logic [31:0] expVal,
                            input logic accept);
        checks++;
        if (dispIndex !== modelTail) begin
            errors++;
            $display("FAIL disp_index got %0d want %0d", dispIndex, modelTail);
        end
        if (expCommit) sbQ.push_back('{isSt, d, expVal, modelTail});
        dispValid = 1; dispType = t; dispDest = d; dispReady = rdy; dispValue = v;
        dispPredTaken = pred; dispAltPc = alt;
        tick();
        dispValid = 0;
        if (accept) modelTail = modelTail + 4'd1;
    endtask

    task automatic wbOne(input logic [3:0] idx, input logic [31:0] val);
        wbValid = 2'b01; wbIndex = {4'd0, idx}; wbValue = {32'd0, val};
        tick();
        wbValid = 2'b00;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (empty === 1'b1 && sbQ.size() == 0) break;
            tick();
        end
        checks++;
        if (!(empty === 1'b1 && sbQ.size() == 0)) begin
            errors++;
            $display("FAIL %s_drain got empty=%0b pending=%0d want empty=1 pending=0",
                     name, empty, sbQ.size());
        end
    endtask

    task automatic test_reset;
        applyReset();
        checks++;
        if (empty !== 1 || full !== 0 || clear !== 0 || newPc !== 0 || dispIndex !== 0 ||
            regCommitValid !== 0 || regCommitDest !== 0 || regCommitValue !== 0 ||
            regCommitIndex !== 0 || storeCommitValid !== 0 || storeCommitIndex !== 0) begin
            errors++;
            $display("FAIL reset_state got empty=%0b full=%0b clear=%0b newPc=%h rcv=%0b st=%0b want empty=1 rest 0",
                     empty, full, clear, newPc, regCommitValid, storeCommitValid);
        end
    endtask

    task automatic test_in_order;
        for (int i = 0; i < 3; i++)
            dispatch(ENT_REG, 5'(i + 1), 0, 0, 0, 0, 1, 0, 32'h1000 + i, 1);
        wbOne(4'd2, 32'h1002);
        wbOne(4'd0, 32'h1000);
        checks++;
        if (regCommitValid !== 1'b0) begin
            errors++;
            $display("FAIL inorder_early got rcv=%0b want 0", regCommitValid);
        end
        wbOne(4'd1, 32'h1001);
        checks++;
        if (regCommitValid !== 1'b1 || regCommitIndex !== 4'd0) begin
            errors++;
            $display("FAIL inorder_first got rcv=%0b idx=%0d want 1 idx 0", regCommitValid, regCommitIndex);
        end
        tick();
        checks++;
        if (regCommitValid !== 1'b1 || regCommitIndex !== 4'd1) begin
            errors++;
            $display("FAIL inorder_second got rcv=%0b idx=%0d want 1 idx 1", regCommitValid, regCommitIndex);
        end
        waitDrain("inorder");
    endtask

    task automatic test_full;
        applyReset();
        for (int i = 0; i < 16; i++) begin
            dispatch(ENT_REG, 5'(i), 0, 0, 0, 0, 1, 0, 32'h2000 + i, 1);
            checks++;
            if (full !== ((i + 1) >= 14)) begin
                errors++;
                $display("FAIL full_level count=%0d got %0b want %0b", i + 1, full, (i + 1) >= 14);
            end
        end
        dispatch(ENT_REG, 5'd31, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        checks++;
        if (full !== 1'b1 || dispIndex !== 4'd0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_overflow got full=%0b idx=%0d empty=%0b want 1 0 0", full, dispIndex, empty);
        end
        for (int i = 0; i < 16; i++) wbOne(4'(i), 32'h2000 + i);
        waitDrain("full");
    endtask

    task automatic test_dual_wb;
        applyReset();
        for (int i = 0; i < 6; i++)
            dispatch(ENT_REG, 5'(i + 8), 0, 0, 0, 0, 1, 0, (i == 5) ? 32'hB : (i == 4) ? 32'h3004 : 32'h3000 + i, 1);
        rs1Dep = 4'd5; rs2Dep = 4'd5;
        #1;
        checks++;
        if (rs1Ready !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle got rs1Ready=%0b want 0", rs1Ready);
        end
        wbValid = 2'b11; wbIndex = {4'd5, 4'd5}; wbValue = {32'hB, 32'hA};
        #1;
        checks++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'hB || rs2Ready !== 1'b1 || rs2Value !== 32'hB) begin
            errors++;
            $display("FAIL bypass_dual got r1=%0b v1=%h r2=%0b v2=%h want 1 B 1 B", rs1Ready, rs1Value, rs2Ready, rs2Value);
        end
        tick();
        wbValid = 2'b00;
        #1;
        checks++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'hB) begin
            errors++;
            $display("FAIL stored_dual got r1=%0b v1=%h want 1 B", rs1Ready, rs1Value);
        end
        rs2Dep = 4'd4;
        #1;
        checks++;
        if (rs2Ready !== 1'b0) begin
            errors++;
            $display("FAIL rs2_notready got %0b want 0", rs2Ready);
        end
        wbValid = 2'b10; wbIndex = {4'd4, 4'd0}; wbValue = {32'h3004, 32'h0};
        #1;
        checks++;
        if (rs2Ready !== 1'b1 || rs2Value !== 32'h3004) begin
            errors++;
            $display("FAIL bypass_ch1 got r2=%0b v2=%h want 1 3004", rs2Ready, rs2Value);
        end
        tick();
        wbValid = 2'b00;
        for (int i = 0; i < 4; i++) wbOne(4'(i), 32'h3000 + i);
        waitDrain("dualwb");
    endtask

    task automatic test_branch;
        applyReset();
        dispatch(ENT_BRANCH, 0, 1, 32'h1, 1, 32'h400, 0, 0, 0, 1);
        dispatch(ENT_STORE, 0, 1, 0, 0, 0, 1, 1, 0, 1);
        dispatch(ENT_REG, 5'd7, 1, 32'h55, 0, 0, 1, 0, 32'h55, 1);
        dispatch(ENT_BRANCH, 0, 0, 0, 0, 32'h100, 0, 0, 0, 1);
        dispatch(ENT_REG, 5'd9, 1, 32'h77, 0, 0, 0, 0, 0, 1);
        repeat (4) tick();
        checks++;
        if (sbQ.size() != 0 || clear !== 1'b0) begin
            errors++;
            $display("FAIL branch_prefix got pending=%0d clear=%0b want 0 0", sbQ.size(), clear);
        end
        wbOne(4'd3, 32'h1);
        dispValid = 1; dispType = ENT_REG; dispDest = 5'd3; dispReady = 1; dispValue = 32'h99;
        tick();
        checks++;
        if (clear !== 1'b1 || newPc !== 32'h100 || empty !== 1'b1 || dispIndex !== 4'd0) begin
            errors++;
            $display("FAIL flush_pulse got clear=%0b newPc=%h empty=%0b idx=%0d want 1 100 1 0",
                     clear, newPc, empty, dispIndex);
        end
        tick();
        dispValid = 0;
        checks++;
        if (clear !== 1'b0 || empty !== 1'b1 || dispIndex !== 4'd0) begin
            errors++;
            $display("FAIL flush_after got clear=%0b empty=%0b idx=%0d want 0 1 0", clear, empty, dispIndex);
        end
        modelTail = 0;
        repeat (3) tick();
    endtask

    task automatic test_store;
        applyReset();
        dispatch(ENT_STORE, 0, 1, 0, 0, 0, 1, 1, 0, 1);
        dispatch(ENT_REG, 5'd4, 0, 0, 0, 0, 1, 0, 32'h4444, 1);
        checks++;
        if (storeCommitValid !== 1'b1 || storeCommitIndex !== 4'd0 || empty !== 1'b0 || dispIndex !== 4'd2) begin
            errors++;
            $display("FAIL store_same_cycle got st=%0b idx=%0d empty=%0b tail=%0d want 1 0 0 2",
                     storeCommitValid, storeCommitIndex, empty, dispIndex);
        end
        wbOne(4'd1, 32'h4444);
        waitDrain("store");
    endtask

    task automatic test_async_reset;
        applyReset();
        for (int i = 0; i < 5; i++)
            dispatch(ENT_REG, 5'(i + 1), 0, 0, 0, 0, 1, 0, 32'h5000 + i, 1);
        wbOne(4'd0, 32'h5000);
        tick();
        checks++;
        if (regCommitValid !== 1'b1 || regCommitDest !== 5'd1) begin
            errors++;
            $display("FAIL pre_reset_commit got rcv=%0b dest=%0d want 1 1", regCommitValid, regCommitDest);
        end
        #1 resetIn = 1'b0;
        #1;
        checks++;
        if (empty !== 1 || full !== 0 || clear !== 0 || newPc !== 0 || dispIndex !== 0 ||
            regCommitValid !== 0 || regCommitDest !== 0 || regCommitValue !== 0 ||
            regCommitIndex !== 0 || storeCommitValid !== 0 || storeCommitIndex !== 0) begin
            errors++;
            $display("FAIL async_reset got empty=%0b rcv=%0b dest=%0d val=%h idx=%0d tail=%0d want empty=1 rest 0",
                     empty, regCommitValid, regCommitDest, regCommitValue, regCommitIndex, dispIndex);
        end
        sbQ.delete();
        modelTail = 0;
        @(posedge clockIn);
        #2 resetIn = 1'b1;
        repeat (3) tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_empty got %0b want 1", empty);
        end
    endtask

    initial begin
        resetIn = 1'b0;
        idleInputs();
        modelTail = 0;
        test_reset();
        test_in_order();
        test_full();
        test_dual_wb();
        test_branch();
        test_store();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
